// File: rtl/uart_tx.sv
// UART transmit serializer: pops bytes from the TX FIFO and shifts them out LSB first.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_en,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 fifo_empty,
    output logic                 fifo_rd,
    input  logic [7:0]           fifo_rddata,
    output logic                 txd,
    output logic                 busy,
    output logic                 tx_done
);

    localparam logic [DIV_WIDTH-1:0] CNT_ZERO = {DIV_WIDTH{1'b0}};
    localparam logic [DIV_WIDTH-1:0] CNT_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd5
    } state_t;

`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    state_t                 state_r;
    logic [DIV_WIDTH-1:0]   div_r;
    logic [DIV_WIDTH-1:0]   bit_cnt_r;
    logic [2:0]             bit_idx_r;
    logic [7:0]             shift_r;
`ifdef UART_TX_PARITY_EN
    logic                   par_r;
`endif
    logic                   txd_r;
    logic                   busy_r;
    logic                   tx_done_r;

    logic                   bit_end_s;
    logic                   done_next_s;
    logic                   pop_ok_s;
    logic                   fifo_rd_s;

    // Bit-timing decode and the FIFO pop strobe (IDLE or last STOP clock only)
    always_comb begin
        bit_end_s   = (bit_cnt_r == div_r);
        done_next_s = ((bit_cnt_r + CNT_ONE) == div_r);
        pop_ok_s    = tx_en & ~fifo_empty;
        fifo_rd_s   = pop_ok_s & ((state_r == ST_IDLE) | ((state_r == ST_STOP) & bit_end_s));
    end

    // Frame FSM; txd and tx_done are set one clock ahead so they are registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            div_r     <= CNT_ZERO;
            bit_cnt_r <= CNT_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
`ifdef UART_TX_PARITY_EN
            par_r     <= 1'b0;
`endif
            txd_r     <= 1'b1;
            busy_r    <= 1'b0;
            tx_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    txd_r     <= 1'b1;
                    tx_done_r <= 1'b0;
                    if (pop_ok_s) begin
                        state_r <= ST_LOAD;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    shift_r   <= fifo_rddata;
                    div_r     <= baud_div;
`ifdef UART_TX_PARITY_EN
                    par_r     <= even_parity(fifo_rddata);
`endif
                    bit_cnt_r <= CNT_ZERO;
                    bit_idx_r <= 3'd0;
                    txd_r     <= 1'b0;
                    busy_r    <= 1'b1;
                    tx_done_r <= 1'b0;
                    state_r   <= ST_START;
                end
                ST_START: begin
                    if (bit_end_s) begin
                        bit_cnt_r <= CNT_ZERO;
                        txd_r     <= shift_r[0];
                        state_r   <= ST_DATA;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        bit_cnt_r <= CNT_ZERO;
                        shift_r   <= {1'b0, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            txd_r     <= par_r;
                            state_r   <= ST_PARITY;
`else
                            txd_r     <= 1'b1;
                            tx_done_r <= (div_r == CNT_ZERO);
                            state_r   <= ST_STOP;
`endif
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            txd_r     <= shift_r[1];
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_ONE;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end_s) begin
                        bit_cnt_r <= CNT_ZERO;
                        txd_r     <= 1'b1;
                        tx_done_r <= (div_r == CNT_ZERO);
                        state_r   <= ST_STOP;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    txd_r <= 1'b1;
                    if (bit_end_s) begin
                        bit_cnt_r <= CNT_ZERO;
                        tx_done_r <= 1'b0;
                        if (pop_ok_s) begin
                            state_r <= ST_LOAD;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_ONE;
                        tx_done_r <= done_next_s;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    txd_r     <= 1'b1;
                    busy_r    <= 1'b0;
                    tx_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd = fifo_rd_s;
    assign txd     = txd_r;
    assign busy    = busy_r;
    assign tx_done = tx_done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: FIFO model, per-clock frame scoreboard, vector table
// and hand-written sequences for back-to-back, enable gating, divisor change and reset.
module tb_uart_tx;

    localparam int DW = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tx_en = 1'b0;
    logic [DW-1:0] baud_div = {DW{1'b0}};
    logic          fifo_empty;
    logic          fifo_rd;
    logic [7:0]    fifo_rddata = 8'h00;
    logic          txd;
    logic          busy;
    logic          tx_done;

    always #5 clk = ~clk;

    uart_tx #(.DIV_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .baud_div(baud_div),
        .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_rddata(fifo_rddata),
        .txd(txd), .busy(busy), .tx_done(tx_done)
    );

    // FIFO model: registered read data, pop counters and timing of pops
    logic [7:0] fifo_mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_count = 0;
    int rd_done = 0;
    int bad_rd = 0;
    int cyc = 0;
    int rd_cyc_last = 0;
    int rd_cyc_prev = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd) begin
            if (fifo_empty) bad_rd <= bad_rd + 1;
            if (tx_done) rd_done <= rd_done + 1;
            fifo_rddata <= fifo_mem[rd_ptr[5:0]];
            rd_ptr      <= rd_ptr + 1;
            rd_count    <= rd_count + 1;
            rd_cyc_prev <= rd_cyc_last;
            rd_cyc_last <= cyc;
        end
    end

    typedef struct { logic [7:0] data; int div; logic par; } exp_t;
    typedef struct { int div; logic [7:0] data; logic par; int len; } vec_t;

    exp_t exp_q[$];
    int n_chk = 0;
    int n_err = 0;

    int mon_frames = 0;
    int mon_c = 0;
    int mon_len = 0;
    int mon_gap = 0;
    int mon_gap_last = 0;
    bit mon_in = 1'b0;
    logic [7:0] mon_byte = 8'h00;
    logic mon_par = 1'b0;

    function automatic void check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input int dv);
        exp_t e;
        fifo_mem[wr_ptr[5:0]] = d;
        wr_ptr++;
        e.data = d;
        e.div  = dv;
        e.par  = ^d;
        exp_q.push_back(e);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (mon_frames < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("frame_seen", int'(mon_frames >= n), 1);
    endtask

    task automatic wait_cnt(input int target, input int budget);
        int k = 0;
        while (!(mon_in && mon_c == target) && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("frame_pos_reached", int'(mon_in && mon_c == target), 1);
    endtask

    // Frame monitor: expected txd / busy / tx_done every clock from the popped scoreboard entry
    task automatic monitor();
        exp_t cur;
        logic [7:0] dec;
        int bl, b, len, etx;
        cur.data = 8'h00; cur.div = 0; cur.par = 1'b0;
        dec = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_in  = 1'b0;
                mon_gap = 0;
            end else begin
                if (!mon_in) begin
                    check("idle_tx_done", int'(tx_done), 0);
                    if (txd == 1'b0) begin
                        check("frame_expected", int'(exp_q.size() > 0), 1);
                        if (exp_q.size() > 0) begin
                            cur = exp_q.pop_front();
                            mon_in = 1'b1;
                            mon_c = 0;
                            mon_gap_last = mon_gap;
                            dec = 8'h00;
                        end
                    end else begin
                        mon_gap++;
                    end
                end
                if (mon_in) begin
                    bl  = cur.div + 1;
                    b   = mon_c / bl;
                    len = NBITS * bl;
                    if (b == 0) etx = 0;
                    else if (b <= 8) etx = int'(cur.data[b-1]);
                    else if (b == 9 && NBITS == 11) etx = int'(cur.par);
                    else etx = 1;
                    check("txd", int'(txd), etx);
                    check("busy_in_frame", int'(busy), 1);
                    check("tx_done_pos", int'(tx_done), int'(mon_c == len - 1));
                    if (b >= 1 && b <= 8 && (mon_c % bl) == bl - 1) dec[b-1] = txd;
                    if (b == 9 && NBITS == 11 && (mon_c % bl) == bl - 1) mon_par = txd;
                    if (tx_done) mon_len = mon_c + 1;
                    if (mon_c == len - 1) begin
                        mon_in = 1'b0;
                        mon_frames++;
                        mon_byte = dec;
                        mon_gap = 0;
                        check("frame_byte", int'(dec), int'(cur.data));
                    end else begin
                        mon_c++;
                    end
                end
            end
        end
    endtask

    initial begin
        vec_t vt[6];
        int r0, f0, d0, viol;

        vt[0] = '{3, 8'h55, 1'b0, NBITS * 4};
        vt[1] = '{0, 8'hFF, 1'b0, NBITS * 1};
        vt[2] = '{2, 8'h07, 1'b1, NBITS * 3};
        vt[3] = '{1, 8'h03, 1'b0, NBITS * 2};
        vt[4] = '{5, 8'h80, 1'b1, NBITS * 6};
        vt[5] = '{0, 8'h01, 1'b1, NBITS * 1};

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", int'(txd), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_tx_done", int'(tx_done), 0);
        check("rst_fifo_rd", int'(fifo_rd), 0);
        rst_n = 1'b1;
        tx_en = 1'b1;
        repeat (5) tick();
        check("idle_busy", int'(busy), 0);
        check("idle_no_pop", rd_count, 0);

        // Single frames from the vector table
        for (int i = 0; i < 6; i++) begin
            baud_div = vt[i].div[DW-1:0];
            r0 = rd_count;
            f0 = mon_frames;
            push(vt[i].data, vt[i].div);
            wait_frames(f0 + 1, 2000);
            repeat (2) tick();
            check("vec_one_pop", rd_count - r0, 1);
            check("vec_len", mon_len, vt[i].len);
            check("vec_byte", int'(mon_byte), int'(vt[i].data));
            check("vec_busy_after", int'(busy), 0);
`ifdef UART_TX_PARITY_EN
            check("vec_parity", int'(mon_par), int'(vt[i].par));
`endif
        end

        // Back-to-back frames
        baud_div = 16'd1;
        r0 = rd_count;
        d0 = rd_done;
        f0 = mon_frames;
        push(8'hA3, 1);
        push(8'h0F, 1);
        wait_frames(f0 + 2, 500);
        repeat (2) tick();
        check("b2b_pops", rd_count - r0, 2);
        check("b2b_pop_spacing", rd_cyc_last - rd_cyc_prev, NBITS * 2 + 1);
        check("b2b_pop_with_done", rd_done - d0, 1);
        check("b2b_high_clocks", mon_gap_last + 2, 3);
        check("b2b_last_byte", int'(mon_byte), 32'h0F);
        check("b2b_busy_after", int'(busy), 0);

        // Enable gating
        tx_en = 1'b0;
        r0 = rd_count;
        push(8'h3C, 1);
        viol = 0;
        repeat (50) begin
            tick();
            if (fifo_rd || !txd || busy) viol++;
        end
        check("gate_idle_violations", viol, 0);
        check("gate_no_pop", rd_count - r0, 0);
        push(8'hC5, 1);
        f0 = mon_frames;
        tx_en = 1'b1;
        wait_cnt(10, 200);
        tx_en = 1'b0;
        wait_frames(f0 + 1, 500);
        repeat (20) tick();
        check("gate_single_pop", rd_count - r0, 1);
        check("gate_busy_after", int'(busy), 0);
        check("gate_fifo_left", int'(fifo_empty), 0);
        tx_en = 1'b1;
        wait_frames(f0 + 2, 500);
        repeat (2) tick();
        check("gate_drain_pops", rd_count - r0, 2);
        check("gate_drain_byte", int'(mon_byte), 32'hC5);

        // Divisor change mid-frame, then divisor 0
        baud_div = 16'd2;
        f0 = mon_frames;
        push(8'h96, 2);
        wait_cnt(7, 200);
        baud_div = 16'd0;
        wait_frames(f0 + 1, 500);
        check("div_frozen_len", mon_len, NBITS * 3);
        push(8'h69, 0);
        wait_frames(f0 + 2, 500);
        check("div_zero_len", mon_len, NBITS);
        check("div_zero_byte", int'(mon_byte), 32'h69);

        // Reset during data bit 4
        baud_div = 16'd1;
        repeat (3) tick();
        r0 = rd_count;
        f0 = mon_frames;
        push(8'hB4, 1);
        wait_cnt(10, 200);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_txd", int'(txd), 1);
        check("mrst_busy", int'(busy), 0);
        check("mrst_tx_done", int'(tx_done), 0);
        check("mrst_fifo_rd", int'(fifo_rd), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) tick();
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_txd", int'(txd), 1);
        check("post_rst_pops", rd_count - r0, 1);
        check("post_rst_no_frame", mon_frames - f0, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        check("never_read_empty", bad_rd, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmit serializer for the Cortex-M0 UART peripheral. It sits directly downstream of the 8-bit transmit FIFO: it pops one byte at a time through the FIFO's read strobe and registered read data, and shifts each byte out on `txd` as an asynchronous serial frame, LSB first. The bit period is set by a runtime clock divisor.

## Interface
- `DIV_WIDTH`, 16: width of the baud divisor input.
- `clk`  input  1  system clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `tx_en`  input  1  transmit enable; gates the start of new frames only.
- `baud_div`  input  DIV_WIDTH  clocks per bit minus 1.
- `fifo_empty`  input  1  TX FIFO empty flag.
- `fifo_rd`  output  1  FIFO pop strobe, combinational, one cycle per byte.
- `fifo_rddata`  input  8  FIFO read data, valid the cycle after `fifo_rd`.
- `txd`  output  1  serial line, registered, idle high.
- `busy`  output  1  high in every state except IDLE.
- `tx_done`  output  1  one-cycle pulse in the last clock of each stop bit.

## Operation
- Reset values: `txd`=1, `fifo_rd`=0, `busy`=0, `tx_done`=0. State is IDLE, and all counters and the shift register are 0.
- States: IDLE, LOAD, START, DATA, PARITY (only when the parity feature is compiled in), STOP.
- IDLE: `fifo_rd` = `tx_en` & !`fifo_empty`. When it is 1, the next state is LOAD.
- LOAD: lasts exactly one cycle.
  - The shift register captures `fifo_rddata`.
  - The divisor register captures `baud_div`. It stays frozen for the whole frame, so changing `baud_div` mid-frame has no effect until the next frame.
  - The next state is START.
- Bit timing: a bit counter counts 0..div. A bit ends when the counter equals div. `baud_div`=0 gives 1 clock per bit.
- START: `txd`=0 for one bit period, then DATA.
- DATA: 8 bits, LSB first. `txd` = shift[0]; the register shifts right at the end of each bit. A 3-bit index counts 0..7; after bit 7 the next state is PARITY if configured, otherwise STOP.
- STOP: `txd`=1 for one bit period. `tx_done` pulses in its final clock. In that same final clock:
  - If `tx_en` & !`fifo_empty`: `fifo_rd`=1 and the next state is LOAD (back-to-back frames).
  - Otherwise the next state is IDLE.
- `fifo_rd` is asserted only in IDLE or in the last STOP clock, and never while `fifo_empty`=1. The FIFO therefore never sees a read of an empty buffer.
- Deasserting `tx_en` mid-frame does not abort the frame; it only prevents the next pop.
- Asynchronous reset mid-frame: `txd` returns to 1 immediately and the frame is lost. The FIFO byte already popped is not restored.

## Timing
- Frame start latency: with `fifo_rd`=1 in cycle N, LOAD is cycle N+1 and `txd` falls at the start of cycle N+2.
- Frame length, 8N1: 10×(div+1) clocks of START+DATA+STOP. With parity: 11×(div+1).
- Back-to-back gap: the LOAD cycle adds exactly 1 clock of `txd`=1 after the stop bit. The line therefore stays high for (div+1)+1 clocks between frames.
- `busy` rises in cycle N+1 (LOAD). It falls in the first IDLE cycle after STOP. It stays high continuously across back-to-back frames.
- `tx_done` and the chained `fifo_rd` occur in the same cycle.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - `txd` = even parity of the latched byte (XOR of its 8 bits) for one bit period.
- Not defined: the PARITY state and its logic are absent, and the frame is 8N1.

## Test plan
- 8N1 single byte: `baud_div`=3, FIFO holds 0x55, `tx_en`=1 → one `fifo_rd` pulse. `txd` sequence, 4 clocks each: 0, 1,0,1,0,1,0,1,0, 1. `tx_done` in clock 40 after `txd` falls. `busy` low afterwards.
- Back-to-back frames: FIFO holds 0xA3 then 0x0F, `baud_div`=1 → two `fifo_rd` pulses 21 clocks apart. The second `fifo_rd` coincides with the first `tx_done`. Bits decode as 0xA3 then 0x0F, with 3 high clocks between frames.
- Enable gating: FIFO non-empty, `tx_en`=0 for 50 clocks → no `fifo_rd`, `txd`=1, `busy`=0. Then deassert `tx_en` midway through a frame → the frame completes, with no further pop.
- Divisor bounds: `baud_div`=0 with byte 0xFF → every bit lasts 1 clock, frame length 10 clocks. Changing `baud_div` during DATA does not change the current frame's bit length.
- Reset mid-frame: assert `rst_n`=0 during DATA bit 4 → `txd`=1, `busy`=0, `tx_done`=0 immediately. After release with the FIFO empty, the block stays idle.
- Parity, with `UART_TX_PARITY_EN`: byte 0x07 → parity bit 1. Byte 0x03 → parity bit 0. Frame length is 11×(div+1).
